// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle processor control unit with retired-instruction counter
module ctrl_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        halted,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [15:0] instr_count
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        RWB      = 4'd3,
        EXEC_I   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        HALT     = 4'd11,
        ILLEGAL  = 4'd12
    } state_t;
    state_t      state_q, state_d;
    logic [3:0]  op_q;
    logic [15:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE)
                op_q <= opcode;
            if (state_d == FETCH && state_q != FETCH)
                cnt_q <= cnt_q + 16'd1;
        end
    end
    always_comb begin
        state_d   = state_q;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        alu_src_a = 1'b0;
        alu_src_b = 2'd0;
        alu_op    = 2'd0;
        wb_sel    = 2'd0;
        ir_write  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'd3;
                case (opcode)
                    4'd0, 4'd1, 4'd2, 4'd3: state_d = EXEC_R;
                    4'd4:                   state_d = EXEC_I;
                    4'd5, 4'd6:             state_d = MEM_ADDR;
                    4'd7, 4'd8:             state_d = BRANCH;
                    4'd9:                   state_d = JUMP;
                    4'd15:                  state_d = HALT;
                    default:                state_d = ILLEGAL;
                endcase
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
                state_d   = RWB;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = RWB;
            end
            RWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = (op_q == 4'd5) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                state_d  = mem_ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                reg_write = 1'b1;
                wb_sel    = 2'd1;
                state_d   = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                state_d   = mem_ready ? FETCH : MEM_WR;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd1;
                pc_src    = 2'd1;
                pc_write  = (op_q == 4'd7) ? zero : ~zero;
                state_d   = FETCH;
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'd2;
                state_d  = FETCH;
            end
            HALT:    halted = 1'b1;
            ILLEGAL: begin
                halted  = 1'b1;
                illegal = 1'b1;
            end
            default: state_d = FETCH;
        endcase
        // reset must also silence the mem_read that FETCH would otherwise drive
        if (!rst_n)
            {pc_write, pc_src, alu_src_a, alu_src_b, alu_op, wb_sel,
             ir_write, mem_read, mem_write, reg_write, halted, illegal} = '0;
    end
    assign state       = state_q;
    assign instr_count = cnt_q;
endmodule
